ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//  Shares one single-port synchronous RAM (my_ram style: address/data/wren in, q out)
//  between two requesters. Each port has a valid/ready request interface.
//  Grants are round-robin: at most one RAM access per clock.
//  Read data is returned to the issuing port with a tagged valid pulse.
//  Sits between producers/consumers and the RAM, in place of a single ram_control.
// PARAMETERS
//  DW      8  data width of RAM and ports
//  AW      8  address width of RAM and ports
//  RD_LAT  1  RAM read latency in cycles, from the RAM address-sample edge to valid q (1..3)
// PORTS
//  clk        in   1   system clock, all logic on rising edge
//  rst_n      in   1   asynchronous active-low reset
//  req0/req1  in   1   port request valid; hold with fields stable until ack
//  we0/we1    in   1   1 = write, 0 = read
//  addr0/1    in   AW  request address
//  wdata0/1   in   DW  write data
//  ack0/ack1  out  1   combinational grant; transfer occurs on an edge with req&ack high
//  rvalid0/1  out  1   one-cycle pulse, rdata holds read result for that port
//  rdata      out  DW  registered read data, shared by both ports
//  ram_addr   out  AW  to RAM address (registered)
//  ram_data   out  DW  to RAM data (registered)
//  ram_wren   out  1   to RAM wren (registered, 1 = write)
//  ram_q      in   DW  from RAM q
// BEHAVIOUR
//  - Reset values: ram_addr=0, ram_data=0, ram_wren=0, rdata=0, rvalid0/1=0, last_grant=1.
//    Port 0 therefore wins the first contention.
//  - Arbitration is combinational from req0, req1 and last_grant. ack0 and ack1 are never
//    high together. If only one port requests, that port is acked in the same cycle.
//  - On contention the port not equal to last_grant wins. last_grant updates on every
//    transfer edge.
//  - Transfer edge (req&ack): ram_addr, ram_data and ram_wren load from the winner's fields.
//  - Edge with no transfer: ram_wren <= 0, ram_addr/ram_data hold. The RAM is never written
//    twice for one request.
//  - Throughput is one transfer per clock. A port may keep req high after ack to issue
//    back-to-back transfers; its next fields are taken on the following edge.
//  - Read latency: if the ack cycle is C0, rvalidN is high in cycle C0+RD_LAT+2 and rdata
//    equals the RAM contents.
//    Pipeline: ram_* registered, then RAM latency, then rdata registered.
//    A port/read tag shift register of depth RD_LAT+1 steers rvalid.
//  - Writes produce no rvalid.
//  - Read-after-write to the same address, either port, in consecutive transfers returns
//    the new data. Accesses are strictly ordered by transfer edge.
//  - rdata updates only when a tagged read completes; otherwise it holds.
//  - Reads from both ports may be in flight simultaneously. rvalid pulses emerge in issue
//    order, at most one per cycle.
//  - Reset mid-operation: all in-flight tags are cleared and no rvalid fires for them.
//    RAM contents are not touched.
//  - Address wrap is the natural AW-bit wrap. The arbiter performs no address arithmetic.
// CONFIGURATION
//  RAM_ARB_FIXED_PRI_EN defined:
//    port 0 always wins contention, last_grant is not used, and port 1 can starve.
//  RAM_ARB_FIXED_PRI_EN undefined (default):
//    round-robin as above; each port waits at most one transfer under contention.
// TESTING
//  1. Reset, req0 write addr=0x10 wdata=0xA5
//     -> ack0=1 same cycle; next cycle ram_addr=0x10, ram_data=0xA5, ram_wren=1;
//        ram_wren=0 after.
//  2. Then req1 read addr=0x10, RD_LAT=1, ack1 in C0
//     -> rvalid1=1 only in C3 with rdata=0xA5; rvalid0 stays 0.
//  3. req0 and req1 held high together for 4 transfers
//     -> grants alternate 0,1,0,1 (defined: 0,0,0,0).
//  4. Port 0 writes 0x3C to 0x20, then port 1 reads 0x20 on the next edge
//     -> rvalid1 with rdata=0x3C.
//  5. Back-to-back reads port0 0x01, port1 0x02 (contents 0x11, 0x22)
//     -> rvalid0/0x11 then rvalid1/0x22 on consecutive cycles.
//  6. Assert rst_n=0 one cycle after a read ack
//     -> no rvalid ever fires; all outputs at reset values; first post-reset contention
//        goes to port 0.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Request/response bundle between two requesters and ram_arbiter.
// master = requester side, slave = arbiter side.
interface ram_arbiter_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          ack0;
    logic          ack1;
    logic          rvalid0;
    logic          rvalid1;
    logic [DW-1:0] rdata;

    modport master (
        output req0, req1, we0, we1,
        output addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, rvalid0, rvalid1, rdata
    );

    modport slave (
        input  req0, req1, we0, we1,
        input  addr0, addr1, wdata0, wdata1,
        output ack0, ack1, rvalid0, rvalid1, rdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of one single-port synchronous RAM.
// RAM_ARB_FIXED_PRI_EN: port 0 always wins contention (port 1 may starve).
module ram_arbiter #(
    parameter int DW     = 8,
    parameter int AW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    ram_arbiter_if.slave  bus,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    output logic          ram_wren,
    input  logic [DW-1:0] ram_q
);

    logic          ack0;
    logic          ack1;
    logic          xfer;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;
    logic          rvalid0;
    logic          rvalid1;
    logic [DW-1:0] rdata;

    // One tag per issued access: valid marks a read, port says who gets it
    logic [RD_LAT:0] tag_vld;
    logic [RD_LAT:0] tag_port;

`ifndef RAM_ARB_FIXED_PRI_EN
    logic last_grant;
`endif

    always_comb begin
        ack0 = 1'b0;
        ack1 = 1'b0;
`ifdef RAM_ARB_FIXED_PRI_EN
        ack0 = bus.req0;
`else
        ack0 = bus.req0 & (~bus.req1 | last_grant);
`endif
        ack1 = bus.req1 & ~ack0;
    end

    assign xfer = ack0 | ack1;

    always_comb begin
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        unique case (1'b1)
            ack1: begin
                sel_we   = bus.we1;
                sel_addr = bus.addr1;
                sel_data = bus.wdata1;
            end
            default: begin
                sel_we   = bus.we0;
                sel_addr = bus.addr0;
                sel_data = bus.wdata0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr <= '0;
            ram_data <= '0;
            ram_wren <= 1'b0;
            tag_vld  <= '0;
            tag_port <= '0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            rdata    <= '0;
        end else begin
            if (xfer) begin
                ram_addr <= sel_addr;
                ram_data <= sel_data;
                ram_wren <= sel_we;
            end else begin
                ram_wren <= 1'b0;
            end
            tag_vld  <= {tag_vld[RD_LAT-1:0], xfer & ~sel_we};
            tag_port <= {tag_port[RD_LAT-1:0], ack1};
            rvalid0  <= tag_vld[RD_LAT] & ~tag_port[RD_LAT];
            rvalid1  <= tag_vld[RD_LAT] & tag_port[RD_LAT];
            if (tag_vld[RD_LAT])
                rdata <= ram_q;
        end
    end

`ifndef RAM_ARB_FIXED_PRI_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant <= 1'b1;
        else if (xfer)
            last_grant <= ack1;
    end
`endif

    assign bus.ack0    = ack0;
    assign bus.ack1    = ack1;
    assign bus.rvalid0 = rvalid0;
    assign bus.rvalid1 = rvalid1;
    assign bus.rdata   = rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural RD_LAT=1 RAM.
// Expectations are hand-computed per step.
module tb_ram_arbiter;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int RD_LAT = 1;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic          ram_wren;
    logic [DW-1:0] ram_q;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    int errors = 0;
    int checks = 0;

    ram_arbiter_if #(.DW(DW), .AW(AW)) bus ();

    ram_arbiter #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_wren (ram_wren),
        .ram_q    (ram_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port RAM: address sampled on the edge, q valid one cycle later
    always_ff @(posedge clk) begin
        if (ram_wren)
            mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.we0 = 1'b0;
        bus.we1 = 1'b0;
        bus.addr0 = '0;
        bus.addr1 = '0;
        bus.wdata0 = '0;
        bus.wdata1 = '0;
    endtask

    task automatic chk_rv(input string tag, input logic e0, input logic e1);
        chk({tag, ".rv0"}, 32'(bus.rvalid0), 32'(e0));
        chk({tag, ".rv1"}, 32'(bus.rvalid1), 32'(e1));
    endtask

    logic exp_a0;

    initial begin
        for (int i = 0; i < (1 << AW); i++)
            mem[i] = '0;
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst.addr", 32'(ram_addr), 32'h0);
        chk("rst.data", 32'(ram_data), 32'h0);
        chk("rst.wren", 32'(ram_wren), 32'h0);
        chk("rst.rdata", 32'(bus.rdata), 32'h0);
        chk_rv("rst", 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();

        // 1: single write from port 0
        bus.req0 = 1'b1;
        bus.we0 = 1'b1;
        bus.addr0 = 8'h10;
        bus.wdata0 = 8'hA5;
        #1;
        chk("t1.ack0", 32'(bus.ack0), 32'h1);
        chk("t1.ack1", 32'(bus.ack1), 32'h0);
        tick();
        idle();
        chk("t1.addr", 32'(ram_addr), 32'h10);
        chk("t1.data", 32'(ram_data), 32'hA5);
        chk("t1.wren", 32'(ram_wren), 32'h1);
        tick();
        chk("t1.wren_off", 32'(ram_wren), 32'h0);

        // 2: port 1 reads it back, rvalid1 in C3
        bus.req1 = 1'b1;
        bus.addr1 = 8'h10;
        #1;
        chk("t2.ack1", 32'(bus.ack1), 32'h1);
        tick();
        idle();
        chk_rv("t2.c1", 1'b0, 1'b0);
        tick();
        chk_rv("t2.c2", 1'b0, 1'b0);
        tick();
        chk_rv("t2.c3", 1'b0, 1'b1);
        chk("t2.rdata", 32'(bus.rdata), 32'hA5);
        tick();
        chk_rv("t2.c4", 1'b0, 1'b0);
        chk("t2.hold", 32'(bus.rdata), 32'hA5);

        // 3: sustained contention, writes so no rvalid traffic
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        bus.we0 = 1'b1;
        bus.we1 = 1'b1;
        bus.addr0 = 8'h30;
        bus.addr1 = 8'h31;
        for (int i = 0; i < 4; i++) begin
            bus.wdata0 = 8'(i);
            bus.wdata1 = 8'(i + 8'h40);
            #1;
`ifdef RAM_ARB_FIXED_PRI_EN
            exp_a0 = 1'b1;
`else
            exp_a0 = (i % 2 == 0);
`endif
            chk($sformatf("t3.ack0[%0d]", i), 32'(bus.ack0), 32'(exp_a0));
            chk($sformatf("t3.ack1[%0d]", i), 32'(bus.ack1), 32'(!exp_a0));
            tick();
        end
        idle();

        // 4: write then read same address on consecutive edges
        bus.req0 = 1'b1;
        bus.we0 = 1'b1;
        bus.addr0 = 8'h20;
        bus.wdata0 = 8'h3C;
        tick();
        idle();
        bus.req1 = 1'b1;
        bus.addr1 = 8'h20;
        #1;
        chk("t4.ack1", 32'(bus.ack1), 32'h1);
        tick();
        idle();
        tick();
        tick();
        chk_rv("t4", 1'b0, 1'b1);
        chk("t4.rdata", 32'(bus.rdata), 32'h3C);

        // 5: seed contents, then back-to-back reads from both ports
        bus.req0 = 1'b1;
        bus.we0 = 1'b1;
        bus.addr0 = 8'h01;
        bus.wdata0 = 8'h11;
        tick();
        bus.addr0 = 8'h02;
        bus.wdata0 = 8'h22;
        tick();
        idle();
        bus.req0 = 1'b1;
        bus.addr0 = 8'h01;
        tick();
        idle();
        bus.req1 = 1'b1;
        bus.addr1 = 8'h02;
        tick();
        idle();
        tick();
        chk_rv("t5.a", 1'b1, 1'b0);
        chk("t5.rdata0", 32'(bus.rdata), 32'h11);
        tick();
        chk_rv("t5.b", 1'b0, 1'b1);
        chk("t5.rdata1", 32'(bus.rdata), 32'h22);

        // 6: reset one cycle after a read ack
        tick();
        bus.req0 = 1'b1;
        bus.addr0 = 8'h10;
        tick();
        idle();
        rst_n = 1'b0;
        #1;
        chk("t6.addr", 32'(ram_addr), 32'h0);
        chk("t6.wren", 32'(ram_wren), 32'h0);
        chk("t6.rdata", 32'(bus.rdata), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk_rv($sformatf("t6.q[%0d]", i), 1'b0, 1'b0);
            tick();
        end
        chk("t6.rdata_hold", 32'(bus.rdata), 32'h0);
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        bus.we0 = 1'b1;
        bus.we1 = 1'b1;
        #1;
        chk("t6.ack0", 32'(bus.ack0), 32'h1);
        chk("t6.ack1", 32'(bus.ack1), 32'h0);
        tick();
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
